// File: rtl/npu_conv_pkg.sv
// Shared types and helpers for the convolver line-buffer front end.
// Holds the feeder state encoding, the default pixel width and the 3-slot rotate helper.
package npu_conv_pkg;

  localparam int CONV_BIT_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_REFILL,
    ST_DONE
  } feeder_state_e;

  // Advance a row-slot index through 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] slot_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/conv_line_ram.sv
// One image row of storage: single write port, single read port with a registered read.
// The read register holds its value whenever re is low.
module conv_line_ram #(
  parameter int BIT_DEPTH = 8,
  parameter int DEPTH     = 28,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [BIT_DEPTH-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [BIT_DEPTH-1:0] rdata
);

  logic [BIT_DEPTH-1:0] mem_q [DEPTH];
  logic [BIT_DEPTH-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/conv_line_feeder.sv
// Producer side of the convolver line-buffer handshake: buffers three rows and streams columns.
// Optional macro ZERO_PAD_EN frames every streamed row with a leading and trailing zero column.
module conv_line_feeder
  import npu_conv_pkg::*;
#(
  parameter int BIT_DEPTH  = CONV_BIT_DEPTH,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIT_DEPTH-1:0] pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic                 shift_buffer,
  output logic [BIT_DEPTH-1:0] in_l1,
  output logic [BIT_DEPTH-1:0] in_l2,
  output logic [BIT_DEPTH-1:0] in_l3,
  output logic                 out_valid,
  output logic                 lines_ready,
  output logic                 row_end,
  output logic                 frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [1:0]    top_q, top_d, wr_slot_q, wr_slot_d, sel_q, sel_d;
  logic          out_valid_q, out_valid_d, row_end_q, row_end_d;
  logic          pix_accept, rd_en;
  logic          wr_last, rd_last;
  logic [BIT_DEPTH-1:0] rdata [3];
`ifdef ZERO_PAD_EN
  logic          lead_q, lead_d, trail_q, trail_d, pad_q, pad_d;
`endif

  assign pix_ready   = (state_q == ST_FILL) || (state_q == ST_REFILL);
  assign lines_ready = (state_q == ST_STREAM);
  assign frame_done  = (state_q == ST_DONE);
  assign pix_accept  = pix_valid && pix_ready;
  assign wr_last     = (wr_col_q == CW'(IMG_WIDTH - 1));
  assign rd_last     = (rd_col_q == CW'(IMG_WIDTH - 1));
  assign out_valid   = out_valid_q;
  assign row_end     = row_end_q;

  for (genvar g = 0; g < 3; g++) begin : g_slot
    conv_line_ram #(
      .BIT_DEPTH (BIT_DEPTH),
      .DEPTH     (IMG_WIDTH),
      .AW        (CW)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (pix_accept && (wr_slot_q == 2'(g))),
      .waddr (wr_col_q),
      .wdata (pix_in),
      .re    (rd_en),
      .raddr (rd_col_q),
      .rdata (rdata[g])
    );
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_col_d    = wr_col_q;
    rd_col_d    = rd_col_q;
    wr_row_d    = wr_row_q;
    top_d       = top_q;
    wr_slot_d   = wr_slot_q;
    sel_d       = sel_q;
    out_valid_d = 1'b0;
    row_end_d   = 1'b0;
    rd_en       = 1'b0;
`ifdef ZERO_PAD_EN
    lead_d      = lead_q;
    trail_d     = trail_q;
    pad_d       = pad_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FILL;
          wr_col_d  = '0;
          rd_col_d  = '0;
          wr_row_d  = '0;
          top_d     = '0;
          wr_slot_d = '0;
`ifdef ZERO_PAD_EN
          lead_d    = 1'b0;
          trail_d   = 1'b0;
`endif
        end
      end

      ST_FILL, ST_REFILL: begin
        if (pix_accept) begin
          wr_col_d = wr_col_q + CW'(1);
          if (wr_last) begin
            wr_col_d  = '0;
            wr_row_d  = wr_row_q + RW'(1);
            wr_slot_d = slot_next(wr_slot_q);
            if (state_q == ST_REFILL) begin
              top_d   = slot_next(top_q);
              state_d = ST_STREAM;
            end else if (wr_row_q == RW'(2)) begin
              state_d = ST_STREAM;
            end
          end
        end
      end

      ST_STREAM: begin
        if (shift_buffer) begin
          out_valid_d = 1'b1;
          sel_d       = top_q;
`ifdef ZERO_PAD_EN
          if (!lead_q) begin
            pad_d  = 1'b1;
            lead_d = 1'b1;
          end else if (trail_q) begin
            pad_d     = 1'b1;
            lead_d    = 1'b0;
            trail_d   = 1'b0;
            row_end_d = 1'b1;
            state_d   = (wr_row_q < RW'(IMG_HEIGHT)) ? ST_REFILL : ST_DONE;
          end else begin
            pad_d    = 1'b0;
            rd_en    = 1'b1;
            rd_col_d = rd_last ? '0 : rd_col_q + CW'(1);
            trail_d  = rd_last;
          end
`else
          rd_en    = 1'b1;
          rd_col_d = rd_last ? '0 : rd_col_q + CW'(1);
          if (rd_last) begin
            row_end_d = 1'b1;
            state_d   = (wr_row_q < RW'(IMG_HEIGHT)) ? ST_REFILL : ST_DONE;
          end
`endif
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_col_q    <= '0;
      rd_col_q    <= '0;
      wr_row_q    <= '0;
      top_q       <= '0;
      wr_slot_q   <= '0;
      sel_q       <= '0;
      out_valid_q <= 1'b0;
      row_end_q   <= 1'b0;
`ifdef ZERO_PAD_EN
      lead_q      <= 1'b0;
      trail_q     <= 1'b0;
      pad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_col_q    <= wr_col_d;
      rd_col_q    <= rd_col_d;
      wr_row_q    <= wr_row_d;
      top_q       <= top_d;
      wr_slot_q   <= wr_slot_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      row_end_q   <= row_end_d;
`ifdef ZERO_PAD_EN
      lead_q      <= lead_d;
      trail_q     <= trail_d;
      pad_q       <= pad_d;
`endif
    end
  end

  function automatic logic [BIT_DEPTH-1:0] slot_data(input logic [1:0] s);
    case (s)
      2'd0:    return rdata[0];
      2'd1:    return rdata[1];
      default: return rdata[2];
    endcase
  endfunction

  // The slot mapping is captured at read time so a later top rotation cannot disturb held outputs.
  always_comb begin
    in_l1 = slot_data(sel_q);
    in_l2 = slot_data(slot_next(sel_q));
    in_l3 = slot_data(slot_next(slot_next(sel_q)));
`ifdef ZERO_PAD_EN
    if (pad_q) begin
      in_l1 = '0;
      in_l2 = '0;
      in_l3 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed self-checking bench for conv_line_feeder with a 4x4 frame, pixel = row*4+col+1.
// Builds with or without ZERO_PAD_EN; expected columns follow the selected framing.
module tb_conv_line_feeder;

  localparam int BD = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef ZERO_PAD_EN
  localparam int NREQ = W + 2;
`else
  localparam int NREQ = W;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [BD-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic          shift_buffer = 1'b0;
  logic [BD-1:0] in_l1, in_l2, in_l3;
  logic          out_valid, lines_ready, row_end, frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  conv_line_feeder #(
    .BIT_DEPTH  (BD),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .shift_buffer (shift_buffer),
    .in_l1        (in_l1),
    .in_l2        (in_l2),
    .in_l3        (in_l3),
    .out_valid    (out_valid),
    .lines_ready  (lines_ready),
    .row_end      (row_end),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 100000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected column k of a streamed row whose top image row is top_row.
  function automatic void exp_col(input int top_row, input int k,
                                  output logic [BD-1:0] a, output logic [BD-1:0] b,
                                  output logic [BD-1:0] c, output logic re);
    int col;
`ifdef ZERO_PAD_EN
    re = (k == W + 1);
    if (k == 0 || k == W + 1) begin
      a = '0; b = '0; c = '0;
      return;
    end
    col = k - 1;
`else
    re  = (k == W - 1);
    col = k;
`endif
    a = BD'(top_row * W + col + 1);
    b = a + BD'(W);
    c = a + BD'(2 * W);
  endfunction

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_pixels(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      pix_in    = BD'(v);
      pix_valid = 1'b1;
      for (int w = 0; w < 20 && !pix_ready; w++) tick();
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({pix_ready, lines_ready, out_valid, row_end, frame_done, in_l1, in_l2, in_l3} !== '0)
      $display("FAIL reset_state: got rdy=%b lr=%b v=%b re=%b fd=%b %0d,%0d,%0d want all 0",
               pix_ready, lines_ready, out_valid, row_end, frame_done, in_l1, in_l2, in_l3);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    begin_frame();
    n_checks++;
    if (pix_ready !== 1'b1) $display("FAIL fill_ready: got %b want 1", pix_ready);
    else n_pass++;
    push_pixels(1, 3 * W);
    n_checks++;
    if ({pix_ready, lines_ready, out_valid} !== 3'b010)
      $display("FAIL fill_done: got rdy=%b lr=%b v=%b want rdy=0 lr=1 v=0",
               pix_ready, lines_ready, out_valid);
    else n_pass++;
  endtask

  // Stray pixels and a start pulse during streaming must not disturb anything.
  task automatic test_stream();
    logic [BD-1:0] a, b, c;
    logic re;
    start = 1'b1; pix_valid = 1'b1; pix_in = 8'd99;
    for (int k = 0; k < NREQ; k++) begin
      if (k == NREQ - 1) begin
        start = 1'b0; pix_valid = 1'b0;
      end
      shift_buffer = 1'b1;
      tick();
      exp_col(0, k, a, b, c, re);
      n_checks++;
      if ({out_valid, row_end, frame_done, in_l1, in_l2, in_l3} !== {1'b1, re, 1'b0, a, b, c})
        $display("FAIL stream_col%0d: got v=%b re=%b fd=%b %0d,%0d,%0d want v=1 re=%b fd=0 %0d,%0d,%0d",
                 k, out_valid, row_end, frame_done, in_l1, in_l2, in_l3, re, a, b, c);
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if ({pix_ready, lines_ready} !== 2'b01)
          $display("FAIL stream_ready: got rdy=%b lr=%b want rdy=0 lr=1", pix_ready, lines_ready);
        else n_pass++;
      end
    end
    tick();
    n_checks++;
    if ({out_valid, pix_ready, in_l1, in_l2, in_l3} !== {1'b0, 1'b1, a, b, c})
      $display("FAIL refill_ignore_shift: got v=%b rdy=%b %0d,%0d,%0d want v=0 rdy=1 %0d,%0d,%0d",
               out_valid, pix_ready, in_l1, in_l2, in_l3, a, b, c);
    else n_pass++;
    shift_buffer = 1'b0;
  endtask

  task automatic test_refill();
    logic [BD-1:0] a, b, c;
    logic re;
    push_pixels(3 * W + 1, 4 * W);
    n_checks++;
    if ({pix_ready, lines_ready} !== 2'b01)
      $display("FAIL refill_done: got rdy=%b lr=%b want rdy=0 lr=1", pix_ready, lines_ready);
    else n_pass++;
    for (int k = 0; k < NREQ; k++) begin
      shift_buffer = 1'b1;
      tick();
      exp_col(1, k, a, b, c, re);
      n_checks++;
      if ({out_valid, row_end, frame_done, in_l1, in_l2, in_l3} !==
          {1'b1, re, (k == NREQ - 1), a, b, c})
        $display("FAIL rotate_col%0d: got v=%b re=%b fd=%b %0d,%0d,%0d want v=1 re=%b fd=%b %0d,%0d,%0d",
                 k, out_valid, row_end, frame_done, in_l1, in_l2, in_l3, re,
                 (k == NREQ - 1), a, b, c);
      else n_pass++;
    end
    shift_buffer = 1'b0;
    tick();
    n_checks++;
    if ({frame_done, out_valid, pix_ready, lines_ready} !== 4'b0000)
      $display("FAIL frame_end: got fd=%b v=%b rdy=%b lr=%b want all 0",
               frame_done, out_valid, pix_ready, lines_ready);
    else n_pass++;
  endtask

  task automatic test_gapped();
    logic [6:0] pat;
    logic [BD-1:0] a, b, c;
    logic re;
    int k;
    pat = 7'b1001101;
    k = 0;
    begin_frame();
    push_pixels(1, 3 * W);
    for (int i = 6; i >= 0; i--) begin
      shift_buffer = pat[i];
      tick();
      if (pat[i]) begin
        exp_col(0, k, a, b, c, re);
        k++;
      end else begin
        re = 1'b0;
      end
      n_checks++;
      if ({out_valid, row_end, in_l1, in_l2, in_l3} !== {pat[i], re, a, b, c})
        $display("FAIL gap_step%0d: got v=%b re=%b %0d,%0d,%0d want v=%b re=%b %0d,%0d,%0d",
                 6 - i, out_valid, row_end, in_l1, in_l2, in_l3, pat[i], re, a, b, c);
      else n_pass++;
    end
    shift_buffer = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [BD-1:0] a, b, c;
    logic re;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    begin_frame();
    push_pixels(1, 3 * W);
    shift_buffer = 1'b1;
    tick();
    tick();
    shift_buffer = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pix_ready, lines_ready, out_valid, row_end, frame_done, in_l1, in_l2, in_l3} !== '0)
      $display("FAIL reset_mid: got rdy=%b lr=%b v=%b re=%b fd=%b %0d,%0d,%0d want all 0",
               pix_ready, lines_ready, out_valid, row_end, frame_done, in_l1, in_l2, in_l3);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    begin_frame();
    push_pixels(1, 3 * W);
    for (int k = 0; k < 2; k++) begin
      shift_buffer = 1'b1;
      tick();
      exp_col(0, k, a, b, c, re);
      n_checks++;
      if ({out_valid, row_end, in_l1, in_l2, in_l3} !== {1'b1, re, a, b, c})
        $display("FAIL restart_col%0d: got v=%b re=%b %0d,%0d,%0d want v=1 re=%b %0d,%0d,%0d",
                 k, out_valid, row_end, in_l1, in_l2, in_l3, re, a, b, c);
      else n_pass++;
    end
    shift_buffer = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_refill();
    test_gapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
